game_period_sched: RTL
======================

// Module: game_period_sched
// PURPOSE
//  Game-period scheduler for the symbol game. Runs on Clk100M and owns the timing.
//  Steps each level through PRELIM, ANSWER and POST, each period a whole number of
//  seconds. Raises the difficulty per level by shortening the symbol-generation
//  tick period, and emits the ClkSymGen and LevelChng strobes for the symbol
//  generator and display logic.
// PARAMETERS
//  TICK_CYCLES  100000000  Clk100M cycles per second; internal prescaler, >=2
//  PRELIM_S     3          PRELIM length in seconds, 1..63
//  ANSWER_S     20         ANSWER length in seconds, 1..63
//  POST_S       2          POST length in seconds, 1..63
//  NUM_LEVELS   5          levels per game, 1..15
//  SYM_BASE     100000000  ClkSymGen period (cycles) at level 1
//  SYM_STEP     5000000    ClkSymGen period reduction per level above 1
//  SYM_MIN      10000000   floor on ClkSymGen period, >=2
// PORTS
//  Clk100M    in   1  system clock, 100 MHz
//  ResetN     in   1  asynchronous active-low reset
//  Start      in   1  level-sampled; starts a game from IDLE or DONE
//  Abort      in   1  level-sampled; returns to IDLE from any state
//  Period     out  2  0=IDLE 1=PRELIM 2=ANSWER 3=POST (0 also in DONE)
//  Level      out  4  current level, 1..NUM_LEVELS; 0 in IDLE
//  SecsLeft   out  6  whole seconds remaining in current period; 0 in IDLE/DONE
//  LevelChng  out  1  one-cycle pulse on every entry to PRELIM
//  ClkSymGen  out  1  one-cycle symbol-generation strobe, ANSWER only
//  Done       out  1  high while in DONE
// BEHAVIOUR
//  - Reset (ResetN=0, async): state IDLE and all outputs 0. Prescaler, SymCnt and SymMax are 0.
//  - All outputs are registered. Every transition takes effect on the next Clk100M edge.
//  - States: IDLE, PRELIM, ANSWER, POST, DONE.
//  - Priority within one cycle: Abort > Start > timer expiry.
//    Abort in any state -> IDLE next cycle, with all outputs cleared.
//  - IDLE/DONE + Start -> PRELIM with Level=1; Start is ignored in other states.
//  - Period entry: SecsLeft<=<period>_S and Prescaler<=0.
//    Each period lasts exactly <period>_S*TICK_CYCLES cycles.
//  - Prescaler counts 0..TICK_CYCLES-1. When it wraps, SecsLeft decrements.
//    The wrap with SecsLeft==1 ends the period instead, and no extra cycle is added.
//  - Period transitions:
//    PRELIM end -> ANSWER.
//    ANSWER end -> POST.
//    POST end with Level<NUM_LEVELS -> PRELIM with Level+1.
//    POST end with Level==NUM_LEVELS -> DONE.
//  - LevelChng is high for exactly the first cycle of each PRELIM, including level 1.
//  - SymMax = max(SYM_BASE-(Level-1)*SYM_STEP, SYM_MIN).
//    Computed in 32-bit unsigned arithmetic; a negative result saturates to SYM_MIN.
//    SymMax is registered on PRELIM entry and held stable through that level.
//  - SymCnt is cleared on ANSWER entry and counts 0..SymMax-1 only while in ANSWER.
//    ClkSymGen=1 on the cycle SymCnt==SymMax-1, after which SymCnt returns to 0.
//    A partial count is discarded when ANSWER ends. ClkSymGen is never high outside ANSWER.
//  - DONE holds Done=1, Period=0, SecsLeft=0, and keeps the final Level value.
//  - Reset or Abort mid-period discards all timing state; the next Start begins at level 1.
// TESTING
//  Bench parameters: TICK_CYCLES=10, PRELIM_S=2, ANSWER_S=3, POST_S=1, NUM_LEVELS=2,
//  SYM_BASE=8, SYM_STEP=3, SYM_MIN=4.
//  1. Reset, then Start pulse at cycle 0 -> Period=1, Level=1, LevelChng=1 at cycle 1.
//     SecsLeft=2 and LevelChng=0 at cycle 2. SecsLeft=1 at cycle 11.
//     Period=2 with SecsLeft=3 at cycle 21.
//  2. Level-1 ANSWER -> exactly 3 ClkSymGen pulses, on ANSWER-relative cycles 7, 15 and 23.
//     POST starts 30 cycles after ANSWER entry.
//  3. Full game -> level 2 PRELIM with LevelChng pulse.
//     Level-2 ANSWER gives 6 pulses at relative cycles 4, 9, 14, 19, 24 and 29.
//     Then Done=1, Period=0 and Level=2 are held after POST.
//  4. SYM_STEP=5 with 3 levels -> level 3 SymMax saturates to 4 (8-10<0).
//     Level 3 gives pulses every 4 cycles.
//  5. Abort and Start asserted together mid-ANSWER -> IDLE next cycle, all outputs 0.
//     A later Start restarts at Level=1.
//  6. ResetN low mid-PRELIM, asynchronously between edges -> outputs 0 immediately.
//     Start in DONE -> PRELIM with Level=1 next cycle.

Source files
------------

// File: rtl/game_period_sched.sv
`timescale 1ns/1ps
// Game-period scheduler: steps each level through PRELIM, ANSWER and POST on a
// one-second prescaler and shortens the symbol-generation strobe period per level.
module game_period_sched #(
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter int unsigned PRELIM_S    = 3,
  parameter int unsigned ANSWER_S    = 20,
  parameter int unsigned POST_S      = 2,
  parameter int unsigned NUM_LEVELS  = 5,
  parameter int unsigned SYM_BASE    = 100000000,
  parameter int unsigned SYM_STEP    = 5000000,
  parameter int unsigned SYM_MIN     = 10000000
) (
  input  logic       Clk100M,
  input  logic       ResetN,
  input  logic       Start,
  input  logic       Abort,
  output logic [1:0] Period,
  output logic [3:0] Level,
  output logic [5:0] SecsLeft,
  output logic       LevelChng,
  output logic       ClkSymGen,
  output logic       Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELIM,
    S_ANSWER,
    S_POST,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] prescaler;
  logic [31:0] prescaler_nxt;
  logic [31:0] sym_cnt;
  logic [31:0] sym_cnt_nxt;
  logic [31:0] sym_max;
  logic [31:0] sym_max_nxt;

  logic [1:0]  period_nxt;
  logic [3:0]  level_nxt;
  logic [5:0]  secs_nxt;
  logic        level_chng_nxt;
  logic        clk_sym_nxt;
  logic        done_nxt;

  logic        in_period;
  logic        tick;
  logic        expire;
  logic        entering;

  // Negative difference saturates to the floor, so late levels never underflow.
  function automatic logic [31:0] calc_sym_max(input logic [3:0] lvl);
    logic [31:0] dec;
    logic [31:0] diff;
    dec  = (32'(lvl) - 32'd1) * SYM_STEP;
    diff = SYM_BASE - dec;
    if ((dec > SYM_BASE) || (diff < SYM_MIN)) begin
      return SYM_MIN;
    end
    return diff;
  endfunction

  assign in_period = (state == S_PRELIM) || (state == S_ANSWER) || (state == S_POST);
  assign tick      = in_period && (prescaler == (TICK_CYCLES - 1));
  assign expire    = tick && (SecsLeft == 6'd1);
  assign entering  = (state_nxt != state);

  always_ff @(posedge Clk100M or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (Abort) begin
      state_nxt = S_IDLE;
    end else if (Start && ((state == S_IDLE) || (state == S_DONE))) begin
      state_nxt = S_PRELIM;
    end else if (expire) begin
      case (state)
        S_PRELIM: state_nxt = S_ANSWER;
        S_ANSWER: state_nxt = S_POST;
        S_POST:   state_nxt = (Level < 4'(NUM_LEVELS)) ? S_PRELIM : S_DONE;
        default:  state_nxt = state;
      endcase
    end
  end

  // Every output is computed from the upcoming state so the registers below
  // present it on the same edge that the state changes.
  always_comb begin
    period_nxt     = 2'd0;
    level_nxt      = Level;
    secs_nxt       = SecsLeft;
    prescaler_nxt  = 32'd0;
    sym_max_nxt    = sym_max;
    sym_cnt_nxt    = 32'd0;
    level_chng_nxt = 1'b0;
    clk_sym_nxt    = 1'b0;
    done_nxt       = 1'b0;

    case (state_nxt)
      S_PRELIM: period_nxt = 2'd1;
      S_ANSWER: period_nxt = 2'd2;
      S_POST:   period_nxt = 2'd3;
      default:  period_nxt = 2'd0;
    endcase

    if (state_nxt == S_IDLE) begin
      level_nxt = 4'd0;
    end else if (entering && (state_nxt == S_PRELIM)) begin
      level_nxt = (state == S_POST) ? 4'(Level + 4'd1) : 4'd1;
    end

    if (entering) begin
      case (state_nxt)
        S_PRELIM: secs_nxt = 6'(PRELIM_S);
        S_ANSWER: secs_nxt = 6'(ANSWER_S);
        S_POST:   secs_nxt = 6'(POST_S);
        default:  secs_nxt = 6'd0;
      endcase
    end else if (tick) begin
      secs_nxt = SecsLeft - 6'd1;
    end

    if (!entering && in_period && !tick) begin
      prescaler_nxt = prescaler + 32'd1;
    end

    if (state_nxt == S_IDLE) begin
      sym_max_nxt = 32'd0;
    end else if (entering && (state_nxt == S_PRELIM)) begin
      sym_max_nxt = calc_sym_max(level_nxt);
    end

    if ((state_nxt == S_ANSWER) && !entering && (sym_cnt != (sym_max - 32'd1))) begin
      sym_cnt_nxt = sym_cnt + 32'd1;
    end

    clk_sym_nxt    = (state_nxt == S_ANSWER) && (sym_cnt_nxt == (sym_max_nxt - 32'd1));
    level_chng_nxt = entering && (state_nxt == S_PRELIM);
    done_nxt       = (state_nxt == S_DONE);
  end

  always_ff @(posedge Clk100M or negedge ResetN) begin
    if (!ResetN) begin
      Period    <= 2'd0;
      Level     <= 4'd0;
      SecsLeft  <= 6'd0;
      LevelChng <= 1'b0;
      ClkSymGen <= 1'b0;
      Done      <= 1'b0;
      prescaler <= 32'd0;
      sym_cnt   <= 32'd0;
      sym_max   <= 32'd0;
    end else begin
      Period    <= period_nxt;
      Level     <= level_nxt;
      SecsLeft  <= secs_nxt;
      LevelChng <= level_chng_nxt;
      ClkSymGen <= clk_sym_nxt;
      Done      <= done_nxt;
      prescaler <= prescaler_nxt;
      sym_cnt   <= sym_cnt_nxt;
      sym_max   <= sym_max_nxt;
    end
  end

endmodule
